// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: rebuilds h/v counters from incoming syncs, measures line/frame timing and tracks lock
// Ports: clk, rst (synchronous, active-high); hsyncIn/vsyncIn syncs in the clk domain;
//   hCount/vCount recovered position; hTotal/hPulse/vTotal/vPulse last measurements;
//   lineStart/frameStart/lockLost single-cycle pulses; locked timing stable; overflow sticky saturation flag.
module vga_timing_monitor #(
   parameter int   CW          = 12,
   parameter logic H_SYNC_NEG  = 1'b1,
   parameter logic V_SYNC_NEG  = 1'b1,
   parameter int   LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hsyncIn,
   input  logic          vsyncIn,
   output logic [CW-1:0] hCount,
   output logic [CW-1:0] vCount,
   output logic [CW-1:0] hTotal,
   output logic [CW-1:0] hPulse,
   output logic [CW-1:0] vTotal,
   output logic [CW-1:0] vPulse,
   output logic          lineStart,
   output logic          frameStart,
   output logic          locked,
   output logic          lockLost,
   output logic          overflow
);
   localparam int MW = $clog2(LOCK_FRAMES + 1);
   localparam logic [CW-1:0] MAX = '1;
   localparam logic [0:0] SEARCH = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;
   logic s_h_q, s_hd_q, s_v_q, s_vd_q;
   logic [CW-1:0] h_count_q, h_count_d, v_count_q, v_count_d, h_total_q, h_total_d, h_pulse_q, h_pulse_d;
   logic [CW-1:0] v_total_q, v_total_d, v_pulse_q, v_pulse_d, v_cnt_q, v_cnt_d, prev_h_q, prev_h_d, prev_v_q, prev_v_d;
   logic [MW-1:0] match_cnt_q, match_cnt_d;
   logic [0:0] state_q, state_d;
   logic prev_valid_q, prev_valid_d, v_pend_q, v_pend_d, frame_ov_q, frame_ov_d, overflow_q, overflow_d;
   logic line_start_q, frame_start_q, lock_lost_q, lock_lost_d;
   logic h_lead, h_trail, v_lead, v_trail, boundary, h_sat, v_sat, sat, match, lock_entry;
   always_comb begin
      h_lead = s_h_q & ~s_hd_q;
      h_trail = ~s_h_q & s_hd_q;
      v_lead = s_v_q & ~s_vd_q;
      v_trail = ~s_v_q & s_vd_q;
      // a vsync edge is honoured on the same or the next hsync leading edge
      boundary = h_lead & (v_pend_q | v_lead);
      h_sat = ~h_lead & (h_count_q == MAX);
      v_sat = h_lead & ~boundary & (v_count_q == MAX);
      sat = h_sat | v_sat;
      h_count_d = h_lead ? '0 : h_sat ? MAX : h_count_q + 1'b1;
      h_total_d = h_lead ? ((h_count_q == MAX) ? '0 : h_count_q + 1'b1) : h_total_q;
      h_pulse_d = h_trail ? h_count_q + 1'b1 : h_pulse_q;
      v_count_d = boundary ? '0 : ~h_lead ? v_count_q : (v_count_q == MAX) ? MAX : v_count_q + 1'b1;
      v_total_d = boundary ? v_count_q + 1'b1 : v_total_q;
      v_pend_d = ~boundary & (v_lead | v_pend_q);
      v_cnt_d = v_lead ? CW'(h_lead) : (h_lead & s_v_q) ? v_cnt_q + 1'b1 : v_cnt_q;
      v_pulse_d = v_trail ? v_cnt_q : v_pulse_q;
      // saturation seen since the last boundary disqualifies that frame from counting toward lock
      frame_ov_d = ~boundary & (frame_ov_q | sat);
      match = (h_total_d == prev_h_q) & (v_total_d == prev_v_q) & (h_total_d != '0) & ~frame_ov_q;
      state_d = state_q;
      match_cnt_d = match_cnt_q;
      prev_valid_d = prev_valid_q;
      prev_h_d = prev_h_q;
      prev_v_d = prev_v_q;
      lock_entry = 1'b0;
      lock_lost_d = 1'b0;
      if (state_q == LOCKED) begin
         if (sat | (h_lead & (h_total_d != prev_h_q)) | (boundary & (v_total_d != prev_v_q))) begin
            state_d = SEARCH;
            match_cnt_d = '0;
            lock_lost_d = 1'b1;
            prev_h_d = h_lead ? h_total_d : prev_h_q;
            prev_v_d = boundary ? v_total_d : prev_v_q;
         end
      end else if (boundary) begin
         if (prev_valid_q & match) begin
            match_cnt_d = match_cnt_q + 1'b1;
            lock_entry = (match_cnt_d == MW'(LOCK_FRAMES));
            state_d = lock_entry ? LOCKED : SEARCH;
         end else begin
            prev_valid_d = 1'b1;
            prev_h_d = h_total_d;
            prev_v_d = v_total_d;
            match_cnt_d = '0;
         end
      end
      overflow_d = (overflow_q | sat) & ~lock_entry;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s_h_q <= 1'b0;
         s_hd_q <= 1'b0;
         s_v_q <= 1'b0;
         s_vd_q <= 1'b0;
         h_count_q <= '0;
         v_count_q <= '0;
         h_total_q <= '0;
         h_pulse_q <= '0;
         v_total_q <= '0;
         v_pulse_q <= '0;
         v_cnt_q <= '0;
         prev_h_q <= '0;
         prev_v_q <= '0;
         match_cnt_q <= '0;
         state_q <= SEARCH;
         prev_valid_q <= 1'b0;
         v_pend_q <= 1'b0;
         frame_ov_q <= 1'b0;
         overflow_q <= 1'b0;
         line_start_q <= 1'b0;
         frame_start_q <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         s_h_q <= hsyncIn ^ H_SYNC_NEG;
         s_hd_q <= s_h_q;
         s_v_q <= vsyncIn ^ V_SYNC_NEG;
         s_vd_q <= s_v_q;
         h_count_q <= h_count_d;
         v_count_q <= v_count_d;
         h_total_q <= h_total_d;
         h_pulse_q <= h_pulse_d;
         v_total_q <= v_total_d;
         v_pulse_q <= v_pulse_d;
         v_cnt_q <= v_cnt_d;
         prev_h_q <= prev_h_d;
         prev_v_q <= prev_v_d;
         match_cnt_q <= match_cnt_d;
         state_q <= state_d;
         prev_valid_q <= prev_valid_d;
         v_pend_q <= v_pend_d;
         frame_ov_q <= frame_ov_d;
         overflow_q <= overflow_d;
         line_start_q <= h_lead;
         frame_start_q <= boundary;
         lock_lost_q <= lock_lost_d;
      end
   end
   assign hCount = h_count_q;
   assign vCount = v_count_q;
   assign hTotal = h_total_q;
   assign hPulse = h_pulse_q;
   assign vTotal = v_total_q;
   assign vPulse = v_pulse_q;
   assign lineStart = line_start_q;
   assign frameStart = frame_start_q;
   assign locked = (state_q == LOCKED);
   assign lockLost = lock_lost_q;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed vectors and corner sequences for vga_timing_monitor
module tb_vga_timing_monitor;
   localparam int VST = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hsyncIn, vsyncIn, hp, vp;
   logic [11:0] hCount, vCount, hTotal, hPulse, vTotal, vPulse;
   logic lineStart, frameStart, locked, lockLost, overflow;
   logic [11:0] p_hCount, p_vCount, p_hTotal, p_hPulse, p_vTotal, p_vPulse;
   logic p_lineStart, p_frameStart, p_locked, p_lockLost, p_overflow;
   int gx = 0, gy = 0, ht = 100, hs = 12, vt = 12, vs = 2, voff = 0, extra = 0, stall = 0;
   int n_ht, n_hs, n_vt, n_vs;
   bit pend = 0, h_act, v_act;
   int n_chk = 0, n_pass = 0;
   typedef struct {
      int ht, hs, vt, vs;
      int e_ht, e_hp, e_vt, e_vp;
   } vec_t;
   vec_t tbl[4];

   vga_timing_monitor dut (
      .clk(clk), .rst(rst), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
      .hCount(hCount), .vCount(vCount), .hTotal(hTotal), .hPulse(hPulse),
      .vTotal(vTotal), .vPulse(vPulse), .lineStart(lineStart), .frameStart(frameStart),
      .locked(locked), .lockLost(lockLost), .overflow(overflow)
   );

   vga_timing_monitor #(.H_SYNC_NEG(1'b0), .V_SYNC_NEG(1'b0)) dut_pos (
      .clk(clk), .rst(rst), .hsyncIn(hp), .vsyncIn(vp),
      .hCount(p_hCount), .vCount(p_vCount), .hTotal(p_hTotal), .hPulse(p_hPulse),
      .vTotal(p_vTotal), .vPulse(p_vPulse), .lineStart(p_lineStart), .frameStart(p_frameStart),
      .locked(p_locked), .lockLost(p_lockLost), .overflow(p_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      hsyncIn = 1'b1; vsyncIn = 1'b1; hp = 1'b0; vp = 1'b0;
      forever begin
         @(negedge clk);
         if (stall > 0) stall--;
         else begin
            gx++;
            if (gx >= ht + extra) begin
               gx = 0; extra = 0; gy++;
               if (gy >= vt) begin
                  gy = 0;
                  if (pend) begin ht = n_ht; hs = n_hs; vt = n_vt; vs = n_vs; pend = 0; end
               end
            end
         end
         h_act = gx < hs;
         v_act = (gy > VST || (gy == VST && gx >= voff)) && (gy < VST + vs || (gy == VST + vs && gx < voff));
         hsyncIn = ~h_act; vsyncIn = ~v_act; hp = h_act; vp = v_act;
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic wait_pos(input int wy, input int wx);
      int n = 0;
      bit hit = 0;
      while (!hit && n < 20000) begin
         @(posedge clk); #1; n++;
         hit = (gy == wy && gx == wx);
      end
      if (!hit) chk("pos_timeout", gy * 1000 + gx, wy * 1000 + wx);
   endtask

   task automatic wait_line();
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!lineStart && n < 6000);
      if (!lineStart) chk("line_timeout", lineStart, 1);
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!frameStart && n < 20000);
      if (!frameStart) chk("frame_timeout", frameStart, 1);
   endtask

   initial begin
      tbl[0] = '{100, 12, 12, 2, 100, 12, 12, 2};
      tbl[1] = '{64, 1, 10, 1, 64, 1, 10, 1};
      tbl[2] = '{60, 3, 8, 1, 60, 3, 8, 1};
      tbl[3] = '{90, 20, 9, 3, 90, 20, 9, 3};
      repeat (5) @(posedge clk);
      #1;
      chk("rst_main_zero", |{hCount, vCount, hTotal, hPulse, vTotal, vPulse, lineStart, frameStart, locked, lockLost, overflow}, 0);
      chk("rst_pos_zero", |{p_hCount, p_vCount, p_hTotal, p_hPulse, p_vTotal, p_vPulse, p_lineStart, p_frameStart, p_locked, p_lockLost, p_overflow}, 0);
      wait_pos(6, 40);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         wait_frame();
         chk($sformatf("lock_at_frame%0d", i), locked, i == 4);
      end
      chk("meas_hTotal", hTotal, 100);
      chk("meas_hPulse", hPulse, 12);
      chk("meas_vTotal", vTotal, 12);
      chk("meas_vPulse", vPulse, 2);
      chk("meas_overflow", overflow, 0);
      wait_pos(8, 5);
      extra = 1;
      wait_line();
      chk("stretch_lockLost", lockLost, 1);
      chk("stretch_locked", locked, 0);
      chk("stretch_hTotal", hTotal, 101);
      for (int i = 1; i <= 3; i++) begin
         wait_frame();
         chk($sformatf("relock_frame%0d", i), locked, i == 3);
      end
      wait_pos(8, 50);
      stall = 5000;
      for (int n = 0; n < 6000 && stall > 0; n++) begin @(posedge clk); #1; end
      chk("stall_hCount", hCount, 4095);
      chk("stall_overflow", overflow, 1);
      chk("stall_locked", locked, 0);
      wait_line();
      chk("stall_hTotal", hTotal, 0);
      wait_frame();
      chk("ovf_f1_locked", locked, 0);
      chk("ovf_f1_overflow", overflow, 1);
      wait_frame();
      chk("ovf_f2_locked", locked, 0);
      wait_frame();
      chk("ovf_f3_locked", locked, 1);
      chk("ovf_f3_overflow", overflow, 0);
      wait_pos(VST, 0);
      wait_line();
      chk("same_edge_frameStart", frameStart, 1);
      chk("same_edge_vCount", vCount, 0);
      wait_line();
      chk("same_edge_next_frameStart", frameStart, 0);
      chk("same_edge_next_vCount", vCount, 1);
      wait_pos(0, 10);
      voff = 3;
      wait_pos(VST, 0);
      wait_line();
      chk("late_v_first_frameStart", frameStart, 0);
      wait_line();
      chk("late_v_next_frameStart", frameStart, 1);
      chk("late_v_next_vCount", vCount, 0);
      wait_pos(0, 10);
      voff = 0;
      for (int k = 0; k < 4; k++) begin
         n_ht = tbl[k].ht; n_hs = tbl[k].hs; n_vt = tbl[k].vt; n_vs = tbl[k].vs;
         pend = 1;
         for (int n = 0; n < 20000 && pend; n++) begin @(posedge clk); #1; end
         repeat (3) wait_frame();
         for (int f = 0; f < 6 && !locked; f++) wait_frame();
         chk($sformatf("v%0d_locked", k), locked, 1);
         chk($sformatf("v%0d_hTotal", k), hTotal, tbl[k].e_ht);
         chk($sformatf("v%0d_hPulse", k), hPulse, tbl[k].e_hp);
         chk($sformatf("v%0d_vTotal", k), vTotal, tbl[k].e_vt);
         chk($sformatf("v%0d_vPulse", k), vPulse, tbl[k].e_vp);
         chk($sformatf("v%0d_pos_hPulse", k), p_hPulse, tbl[k].e_hp);
         chk($sformatf("v%0d_pos_vPulse", k), p_vPulse, tbl[k].e_vp);
      end
      wait_pos(5, 30);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midline_rst_zero", |{hCount, vCount, hTotal, hPulse, vTotal, vPulse, lineStart, frameStart, overflow}, 0);
      chk("midline_rst_locked", locked, 0);
      chk("midline_rst_lockLost", lockLost, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
